// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   Request/response bundle between the control FSM / datapath (master) and
//   the memory responder (slave).
//
//   mem_req       master -> slave  request valid
//   mem_ready     slave -> master  responder idle, request will be accepted
//   mem_we        master -> slave  1 = store, 0 = load
//   mem_addr      master -> slave  byte address
//   mem_wdata     master -> slave  store data, right-aligned
//   mem_size      master -> slave  00 byte, 01 half, 10/11 word
//   mem_unsigned  master -> slave  loads: 1 = zero-extend, 0 = sign-extend
//   mem_done      slave -> master  one-cycle completion pulse
//   mem_rdata     slave -> master  load result, valid with mem_done
//   mem_err       slave -> master  error flag, qualified by mem_done
// ---------------------------------------------------------------------------
interface mem_responder_if;
    logic        mem_req;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned,
        input  mem_ready, mem_done, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned,
        output mem_ready, mem_done, mem_rdata, mem_err
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multi-cycle control FSM's load/store
//   traffic. Accepts one request at a time, waits a fixed LATENCY, performs a
//   little-endian byte/half/word access on an internal word array and returns
//   a one-cycle mem_done pulse together with load data.
//
//   Ports:
//     clk    single clock, rising edge
//     reset  synchronous active-low reset (0 = reset)
//     bus    mem_responder_if.slave (req/ready handshake, access fields,
//            done/rdata/err response)
//
//   Parameters:
//     DEPTH_WORDS  number of 32-bit words, power of 2
//     LATENCY      BUSY cycles between accept and the done cycle, 1..15
//
//   Build option:
//     MEM_ERR_CHECK_EN  when defined, misaligned half/word accesses and
//                       addresses beyond the array raise mem_err and are
//                       suppressed. When undefined, mem_err is tied 0, the
//                       upper address bits wrap and misaligned offsets are
//                       forced aligned.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        done_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // request fields captured on the accepting edge
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_uns;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          fire;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          acc_err;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign bus.mem_ready = (state == IDLE);
    assign bus.mem_done  = done_q;
    assign bus.mem_rdata = rdata_q;

    // reset gating keeps a request from being taken while reset is low
    assign accept = reset && (state == IDLE) && bus.mem_req;
    // the access edge: BUSY with the counter expired, and not being reset
    assign fire   = reset && (state == BUSY) && (cnt == 4'd0);

    assign widx   = lat_addr[AW+1:2];

    // Lane selection. Half accesses drop addr[0] and word accesses use lane 0;
    // with error checking enabled the misaligned cases never write or return
    // data, so the same forced-aligned lane serves both builds.
    always_comb begin
        case (lat_size)
            2'b00:   lane = lat_addr[1:0];
            2'b01:   lane = {lat_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

`ifdef MEM_ERR_CHECK_EN
    always_comb begin
        acc_err = 1'b0;
        if (lat_size == 2'b01 && lat_addr[0])
            acc_err = 1'b1;
        if (lat_size[1] && lat_addr[1:0] != 2'b00)
            acc_err = 1'b1;
        if (lat_addr[31:AW+2] != '0)
            acc_err = 1'b1;
    end
`else
    // upper address bits simply wrap; nothing consumes them
    logic unused_addr_hi;
    assign unused_addr_hi = ^lat_addr[31:AW+2];
    assign acc_err        = 1'b0;
`endif

    // load path: shift the selected lane down, then extend
    assign rd_word  = mem[widx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        case (lat_size)
            2'b00:   load_val = lat_uns ? {24'd0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = lat_uns ? {16'd0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // store path: replicate data across the word and pick bytes by enable
    always_comb begin
        case (lat_size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << lane;
                wd = {2{lat_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = lat_wdata;
            end
        endcase
    end

    // array contents survive reset; only the write is reset-qualified (via fire)
    always_ff @(posedge clk) begin
        if (fire && lat_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            done_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        err_q  <= acc_err;
                        if (!lat_we)
                            rdata_q <= acc_err ? 32'd0 : load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // request capture needs no reset: fields are only consumed after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= bus.mem_we;
            lat_addr  <= bus.mem_addr;
            lat_wdata <= bus.mem_wdata;
            lat_size  <= bus.mem_size;
            lat_uns   <= bus.mem_unsigned;
        end
    end

`ifdef MEM_ERR_CHECK_EN
    assign bus.mem_err = err_q;
`else
    logic unused_err;
    assign unused_err  = err_q;
    assign bus.mem_err = 1'b0;
`endif

endmodule
